// File: rtl/status_flag_if.sv
// status_flag_if: ALU-side inputs, stack/flag commands and registered flag/stack status of status_flag_unit
// Ports (signals):
//   alu_a, alu_b, alu_result  ALU operands and result (WIDTH bits)
//   alu_carry_out             add carry / sub borrow
//   shift_out                 last bit shifted out
//   op_class                  00 logic, 01 add, 10 sub, 11 shift
//   update_flags, flags_push, flags_pop, clear_error  commands
//   zero_flag, carry_flag, sign_flag, overflow_flag   registered flags
//   stack_full, stack_empty, stack_error              stack status
// Modports: master drives commands/ALU data, slave is the flag unit.
interface status_flag_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry_out;
   logic             shift_out;
   logic [1:0]       op_class;
   logic             update_flags;
   logic             flags_push;
   logic             flags_pop;
   logic             clear_error;
   logic             zero_flag;
   logic             carry_flag;
   logic             sign_flag;
   logic             overflow_flag;
   logic             stack_full;
   logic             stack_empty;
   logic             stack_error;
   modport master (
      output alu_a, alu_b, alu_result, alu_carry_out, shift_out, op_class,
             update_flags, flags_push, flags_pop, clear_error,
      input  zero_flag, carry_flag, sign_flag, overflow_flag,
             stack_full, stack_empty, stack_error
   );
   modport slave (
      input  alu_a, alu_b, alu_result, alu_carry_out, shift_out, op_class,
             update_flags, flags_push, flags_pop, clear_error,
      output zero_flag, carry_flag, sign_flag, overflow_flag,
             stack_full, stack_empty, stack_error
   );
endinterface

// File: rtl/status_flag_unit.sv
// status_flag_unit: registered Z/C/S/O flags derived from ALU results, with a LIFO flag-save stack
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      status_flag_if.slave: ALU data, commands, flags and stack status
module status_flag_unit #(
   parameter int WIDTH       = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   status_flag_if.slave   bus
);
   localparam int PW = $clog2(STACK_DEPTH + 1);
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int M  = WIDTH - 1;
   // flags and stack entries are packed {Z,C,S,O}
   logic [3:0]    flags;
   logic [3:0]    flags_next;
   logic [3:0]    derived;
   logic [3:0]    stack_mem [2**AW];
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic          err;
   logic          full;
   logic          empty;
   logic          carry;
   logic          ovf;
   logic          pop_ok;
   logic          push_ok;
   logic          set_err;
   assign full   = ptr == PW'(STACK_DEPTH);
   assign empty  = ptr == '0;
   assign wr_idx = AW'(ptr);
   assign rd_idx = AW'(ptr - PW'(1));
   always_comb begin
      carry   = bus.op_class == 2'b00 ? 1'b0 : bus.op_class == 2'b11 ? bus.shift_out : bus.alu_carry_out;
      ovf     = bus.op_class == 2'b01 ? (bus.alu_a[M] == bus.alu_b[M]) && (bus.alu_result[M] != bus.alu_a[M]) :
                bus.op_class == 2'b10 ? (bus.alu_a[M] != bus.alu_b[M]) && (bus.alu_result[M] != bus.alu_a[M]) : 1'b0;
      derived = {bus.alu_result == '0, carry, bus.alu_result[M], ovf};
      pop_ok  = bus.flags_pop && !bus.flags_push && !empty;
      push_ok = bus.flags_push && !bus.flags_pop && !full;
      set_err = (bus.flags_push && bus.flags_pop) || (bus.flags_pop && !bus.flags_push && empty) ||
                (bus.flags_push && !bus.flags_pop && full);
      // a successful pop overrides any update in the same cycle
      flags_next = pop_ok ? stack_mem[rd_idx] : bus.update_flags ? derived : flags;
      ptr_next   = pop_ok ? ptr - PW'(1) : push_ok ? ptr + PW'(1) : ptr;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags <= '0;
         ptr   <= '0;
         err   <= 1'b0;
      end else begin
         flags <= flags_next;
         ptr   <= ptr_next;
         err   <= set_err ? 1'b1 : bus.clear_error ? 1'b0 : err;
      end
   end
   // storage is deliberately unreset; only the pointer defines valid entries
   always_ff @(posedge clk) begin
      if (push_ok) stack_mem[wr_idx] <= flags;
   end
   assign bus.zero_flag     = flags[3];
   assign bus.carry_flag    = flags[2];
   assign bus.sign_flag     = flags[1];
   assign bus.overflow_flag = flags[0];
   assign bus.stack_full    = full;
   assign bus.stack_empty   = empty;
   assign bus.stack_error   = err;
endmodule

// File: tb/tb_status_flag_unit.sv
// tb_status_flag_unit: scoreboard bench for status_flag_unit against a queue-based flag/stack model
module tb_status_flag_unit;
   localparam int W = 16;
   localparam int D = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;
   status_flag_if #(.WIDTH(W)) bus ();
   status_flag_unit #(.WIDTH(W), .STACK_DEPTH(D)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );
   int errors = 0;
   int checks = 0;
   logic [3:0] m_flags = '0;
   logic [3:0] m_stack [$];
   bit         m_err = 1'b0;
   logic [6:0] exp_q [$];
   function automatic logic [6:0] dut_out();
      return {bus.zero_flag, bus.carry_flag, bus.sign_flag, bus.overflow_flag,
              bus.stack_full, bus.stack_empty, bus.stack_error};
   endfunction
   function automatic logic [6:0] m_out();
      return {m_flags, m_stack.size() == D, m_stack.size() == 0, m_err};
   endfunction
   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got ZCSO_full_empty_err=%b expected %b", name, $time, act, exp);
      end
   endtask
   task automatic idle();
      bus.update_flags = 1'b0;
      bus.flags_push   = 1'b0;
      bus.flags_pop    = 1'b0;
      bus.clear_error  = 1'b0;
   endtask
   // drives one cycle of stimulus with a self-consistent ALU result and records the expected outputs
   task automatic op_step(input logic push, input logic pop, input logic upd, input logic clr,
                          input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic         cy;
      logic         so;
      logic         c;
      logic         o;
      int           sr;
      bit           set;
      logic [3:0]   der;
      r  = op == 2'd0 ? a ^ b : op == 2'd1 ? a + b : op == 2'd2 ? a - b : {a[W-2:0], 1'b0};
      cy = op == 2'd1 ? ({1'b0, a} + {1'b0, b}) > (2**W - 1) : op == 2'd2 ? a < b : 1'($urandom_range(0, 1));
      so = op == 2'd3 ? a[W-1] : 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.alu_a = a;
      bus.alu_b = b;
      bus.alu_result = r;
      bus.alu_carry_out = cy;
      bus.shift_out = so;
      bus.op_class = op;
      bus.flags_push = push;
      bus.flags_pop = pop;
      bus.update_flags = upd;
      bus.clear_error = clr;
      sr = op == 2'd1 ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
      o  = (op == 2'd1 || op == 2'd2) && (sr > 32767 || sr < -32768);
      c  = op == 2'd0 ? 1'b0 : op == 2'd3 ? so : cy;
      der = {r == '0, c, r[W-1], o};
      set = 1'b0;
      if (push && pop) begin
         set = 1'b1;
         if (upd) m_flags = der;
      end else if (pop) begin
         if (m_stack.size() > 0) m_flags = m_stack.pop_back();
         else begin
            set = 1'b1;
            if (upd) m_flags = der;
         end
      end else begin
         if (push) begin
            if (m_stack.size() < D) m_stack.push_back(m_flags);
            else set = 1'b1;
         end
         if (upd) m_flags = der;
      end
      m_err = set ? 1'b1 : clr ? 1'b0 : m_err;
      exp_q.push_back(m_out());
   endtask
   task automatic reset_pulse();
      @(posedge clk);
      #3;
      bus.update_flags = 1'b1;
      bus.flags_push = 1'b1;
      bus.alu_result = 16'h8001;
      bus.op_class = 2'd3;
      bus.shift_out = 1'b1;
      reset_n = 1'b0;
      #1;
      check("reset_immediate", dut_out(), 7'b0000_010);
      m_flags = '0;
      m_stack.delete();
      m_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_held", dut_out(), 7'b0000_010);
      idle();
      reset_n = 1'b1;
   endtask
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) check("cycle", dut_out(), exp_q.pop_front());
   end
   initial begin
      bus.alu_a = '0;
      bus.alu_b = '0;
      bus.alu_result = '0;
      bus.alu_carry_out = 1'b0;
      bus.shift_out = 1'b0;
      bus.op_class = 2'd0;
      idle();
      reset_pulse();
      op_step(0, 0, 1, 0, 2'd2, 16'h0005, 16'h0007);
      op_step(0, 0, 1, 0, 2'd1, 16'h7FFF, 16'h0001);
      op_step(0, 0, 1, 0, 2'd2, 16'h8000, 16'h0001);
      op_step(0, 0, 1, 0, 2'd0, 16'h1234, 16'h1234);
      op_step(0, 0, 1, 0, 2'd3, 16'hC000, 16'h0000);
      op_step(0, 0, 0, 0, 2'd1, 16'h0000, 16'h0000);
      op_step(1, 0, 1, 0, 2'd2, 16'h0005, 16'h0007);
      op_step(1, 0, 1, 0, 2'd1, 16'h7FFF, 16'h0001);
      op_step(1, 0, 1, 0, 2'd2, 16'h8000, 16'h0001);
      op_step(1, 0, 1, 0, 2'd0, 16'h00F0, 16'h00F0);
      op_step(1, 0, 1, 0, 2'd1, 16'hFFFF, 16'h0001);
      repeat (4) op_step(0, 1, 1, 0, 2'd1, 16'h7FFF, 16'h7FFF);
      op_step(0, 1, 0, 0, 2'd0, 16'h0000, 16'h0000);
      op_step(0, 0, 0, 1, 2'd0, 16'h0000, 16'h0000);
      op_step(1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000);
      op_step(1, 1, 1, 0, 2'd2, 16'h0001, 16'h0002);
      op_step(0, 0, 0, 1, 2'd0, 16'h0000, 16'h0000);
      op_step(1, 0, 1, 0, 2'd1, 16'h8000, 16'h8000);
      op_step(0, 1, 0, 0, 2'd0, 16'h0000, 16'h0000);
      op_step(0, 1, 1, 0, 2'd1, 16'h0001, 16'h0001);
      op_step(1, 1, 0, 1, 2'd0, 16'h0000, 16'h0000);
      for (int i = 0; i < 600; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom);
         b = $urandom_range(0, 3) == 0 ? a : W'($urandom);
         if (i == 300) reset_pulse();
         op_step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), a, b);
      end
      @(negedge clk);
      idle();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Produces the registered zero, carry, sign and overflow flags consumed by the datapath's conditional-jump evaluation. The unit derives flags from each ALU result and latches them on command. A small LIFO saves and restores flags around calls and interrupts. It sits between the ALU output and the jump-condition logic, and is the only writer of the architectural flags.

## Interface
- `WIDTH`, 16, ALU operand/result width in bits (≥2)
- `STACK_DEPTH`, 4, number of flag-save entries (≥1)

- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `alu_a`  in  WIDTH  ALU operand A
- `alu_b`  in  WIDTH  ALU operand B (subtrahend for sub)
- `alu_result`  in  WIDTH  ALU result for this operation
- `alu_carry_out`  in  1  ALU carry for add; borrow (1 = A<B unsigned) for sub
- `shift_out`  in  1  last bit shifted out by the ALU
- `op_class`  in  2  00 logic, 01 add, 10 sub, 11 shift
- `update_flags`  in  1  latch flags derived from the current ALU inputs
- `flags_push`  in  1  save current registered flags to stack
- `flags_pop`  in  1  restore flags from top of stack
- `clear_error`  in  1  clear sticky `stack_error`
- `zero_flag`, `carry_flag`, `sign_flag`, `overflow_flag`  out  1 each  registered flags
- `stack_full`  out  1  stack holds STACK_DEPTH entries
- `stack_empty`  out  1  stack holds 0 entries
- `stack_error`  out  1  sticky; set on illegal stack operation

## Operation
Next-flag derivation is combinational, with `m` = MSB:
- Z = (alu_result == 0); S = alu_result[m]
- logic: C=0, O=0
- add: C=alu_carry_out; O = (a[m]==b[m]) & (r[m]!=a[m])
- sub: C=alu_carry_out (borrow); O = (a[m]!=b[m]) & (r[m]!=a[m])
- shift: C=shift_out, O=0

Per-cycle actions, evaluated at the rising edge:
- `flags_push` & `flags_pop` both high: illegal. Stack and flags are unchanged, `stack_error` is set, and `update_flags` is still honoured.
- `flags_pop` only:
  - If not empty: flags ← top entry, pointer−1. `update_flags` is discarded this cycle.
  - If empty: no change, `stack_error` is set, and `update_flags` is honoured.
- `flags_push` only:
  - If not full: the entry at the pointer ← current registered flags (the pre-update value), pointer+1.
  - If full: no stack change, `stack_error` is set.
  - In both cases `update_flags` is honoured in the same cycle.
- `update_flags` with no stack operation: flags ← derived flags.
- No enable: all state holds.

Stack storage and status:
- The stack is an array of 4-bit entries {Z,C,S,O} with a pointer of width clog2(STACK_DEPTH+1).
- `stack_full` = (pointer==STACK_DEPTH); `stack_empty` = (pointer==0). Both are decoded from the registered pointer.
- `stack_error`:
  - Sticky until `clear_error`.
  - If a set condition and `clear_error` occur in the same cycle, set wins.
- Stack contents are not reset; only the pointer is.

Reset (`reset_n` low, asynchronous, any time including mid-push/pop):
- All flags 0, pointer 0, `stack_empty`=1, `stack_full`=0, `stack_error`=0.
- An operation in flight on the edge where reset asserts has no effect.

## Timing
- Flags, pointer and error are registered, so every output changes only on the clock edge or on reset assertion.
- `update_flags` in cycle N: new flags are visible in cycle N+1. Jump evaluation in N+1 sees them.
- Push/pop: the stack and flags update at the end of the request cycle. `stack_full`/`stack_empty` reflect the new pointer in the following cycle.
- There is no combinational path from any input to any output.
- Back-to-back operations every cycle are supported. Push then pop in consecutive cycles returns the pushed value.

## Test plan
- Reset: assert `reset_n`=0 mid-cycle → all flags 0, `stack_empty`=1, `stack_full`=0, `stack_error`=0 immediately.
- Sub 0x0005−0x0007 with r=0xFFFE, borrow=1, `update_flags` → next cycle Z=0, C=1, S=1, O=0.
- Add 0x7FFF+0x0001 with r=0x8000, carry=0 → Z=0, C=0, S=1, O=1.
- Sub 0x8000−0x0001 with r=0x7FFF, borrow=0 → O=1, S=0, C=0, Z=0.
- Logic op with r=0x0000 → Z=1, C=0, O=0, S=0.
- Stack sequence, STACK_DEPTH=4:
  - Push 4 distinct flag sets → `stack_full`=1.
  - 5th push → `stack_error`=1, contents intact.
  - 4 pops → LIFO order restored, `stack_empty`=1.
  - Extra pop → flags unchanged, error stays 1.
  - `clear_error` → error 0.
  - Push+pop in the same cycle → error set, pointer unchanged.
  - Push+update in the same cycle → stack holds the old flags, flags hold the new values.
